// File: rtl/cpu_cycle_pkg.sv
// -----------------------------------------------------------------------------
// cpu_cycle_pkg
// Shared constants and helpers for the CPU cycle generator.
//   - Default values for the cpu_cycle_gen parameters.
//   - Width and saturation value of the wait-state counter.
//   - in_region(): address-window compare used for the slow-region decision.
// -----------------------------------------------------------------------------
package cpu_cycle_pkg;

    // Defaults for cpu_cycle_gen parameters
    localparam int unsigned DEF_DIV        = 4;
    localparam logic [15:0] DEF_SLOW_BASE  = 16'h2000;
    localparam logic [15:0] DEF_SLOW_MASK  = 16'hE000;
    localparam int unsigned DEF_SLOW_WS    = 2;
    localparam int unsigned DEF_NUM_IRQ    = 4;
    localparam int unsigned DEF_RST_CYCLES = 8;

    // Wait-state counter
    localparam int unsigned WCNT_W = 4;
    typedef logic [WCNT_W-1:0] wcnt_t;
    localparam wcnt_t WCNT_MAX = '1;

    // CPU reset hold counter
    localparam int unsigned RST_CNT_W = 8;
    typedef logic [RST_CNT_W-1:0] rst_cnt_t;
    localparam rst_cnt_t RST_CNT_MAX = '1;

    // True when addr falls inside the window described by base/mask.
    function automatic logic in_region(input logic [15:0] addr,
                                       input logic [15:0] base,
                                       input logic [15:0] mask);
        return (addr & mask) == base;
    endfunction

endpackage

// File: rtl/sync2.sv
// -----------------------------------------------------------------------------
// sync2
// Two-flop synchroniser for asynchronous level inputs, WIDTH bits wide.
// Each bit is synchronised independently; output lags input by 2 clk.
// Ports:
//   clk    in   system clock
//   reset  in   asynchronous, active-high; clears both stages
//   d      in   asynchronous input levels
//   q      out  synchronised levels
// -----------------------------------------------------------------------------
module sync2 #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= '0;
            q      <= '0;
        end else begin
            meta_q <= d;
            q      <= meta_q;
        end
    end

endmodule

// File: rtl/cpu_cycle_gen.sv
// -----------------------------------------------------------------------------
// cpu_cycle_gen
// Generates the CPU cycle timing from the system clock: a phase counter of DIV
// clocks per CPU cycle, a one-clk advance strobe (phi0_en), the bus phase
// (phi2), wait-state stretching for a slow address window and an external wait
// request, registered interrupt/NMI lines toward the core, and the core reset
// release after RST_CYCLES CPU cycles.
//
// All outputs are registered. phi0_en, irq_n, nmi_n and cpu_reset_n change on
// the same clk edge that wraps the phase counter back to 0, so the core sees a
// consistent picture during the first clk of each new CPU cycle.
//
// Ports:
//   clk          in   system clock
//   reset        in   asynchronous, active-high
//   cpu_a        in   address of the current CPU cycle (sampled at last phase)
//   ext_wait     in   external wait request, level, asynchronous
//   irq_src      in   interrupt levels, active high, asynchronous
//   irq_mask     in   per-source interrupt enable
//   nmi_src      in   NMI request, asynchronous, rising-edge significant
//   phi0_en      out  one-clk CPU advance strobe
//   phi2         out  bus phase, high in second half of the cycle
//   irq_n        out  interrupt to core, active low
//   nmi_n        out  NMI to core, active low, one CPU cycle per request
//   cpu_reset_n  out  reset to core, active low
//   wait_active  out  high while a cycle is being stretched
// -----------------------------------------------------------------------------
module cpu_cycle_gen
    import cpu_cycle_pkg::*;
#(
    parameter int unsigned DIV        = DEF_DIV,
    parameter logic [15:0] SLOW_BASE  = DEF_SLOW_BASE,
    parameter logic [15:0] SLOW_MASK  = DEF_SLOW_MASK,
    parameter int unsigned SLOW_WS    = DEF_SLOW_WS,
    parameter int unsigned NUM_IRQ    = DEF_NUM_IRQ,
    parameter int unsigned RST_CYCLES = DEF_RST_CYCLES
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [15:0]        cpu_a,
    input  logic               ext_wait,
    input  logic [NUM_IRQ-1:0] irq_src,
    input  logic [NUM_IRQ-1:0] irq_mask,
    input  logic               nmi_src,
    output logic               phi0_en,
    output logic               phi2,
    output logic               irq_n,
    output logic               nmi_n,
    output logic               cpu_reset_n,
    output logic               wait_active
);

    localparam int unsigned PH_W = (DIV > 2) ? $clog2(DIV) : 1;

    localparam logic [PH_W-1:0] PH_LAST = PH_W'(DIV - 1);
    localparam logic [PH_W-1:0] PH_HALF = PH_W'(DIV / 2);
    localparam wcnt_t           WS_LIM  = WCNT_W'(SLOW_WS);
    localparam rst_cnt_t        RST_LIM = RST_CNT_W'(RST_CYCLES);

    // Synchronised inputs
    logic               ext_wait_s;
    logic [NUM_IRQ-1:0] irq_s;
    logic               nmi_s;

    // State
    logic [PH_W-1:0] ph_q, ph_d;
    wcnt_t           wcnt_q, wcnt_d;
    rst_cnt_t        rst_cnt_q, rst_cnt_d;
    logic            nmi_prev_q;
    logic            nmi_pend_q, nmi_pend_d;

    // Next-state for registered outputs
    logic irq_n_d;
    logic nmi_n_d;
    logic cpu_reset_n_d;

    // Decode
    logic at_end;
    logic slow;
    logic stall;
    logic advance;
    logic nmi_edge;

    sync2 #(
        .WIDTH (1)
    ) u_sync_wait (
        .clk   (clk),
        .reset (reset),
        .d     (ext_wait),
        .q     (ext_wait_s)
    );

    sync2 #(
        .WIDTH (NUM_IRQ)
    ) u_sync_irq (
        .clk   (clk),
        .reset (reset),
        .d     (irq_src),
        .q     (irq_s)
    );

    sync2 #(
        .WIDTH (1)
    ) u_sync_nmi (
        .clk   (clk),
        .reset (reset),
        .d     (nmi_src),
        .q     (nmi_s)
    );

    always_comb begin
        at_end  = (ph_q == PH_LAST);
        slow    = in_region(cpu_a, SLOW_BASE, SLOW_MASK);
        // Address and wait request only matter in the last phase; elsewhere
        // the cycle always runs freely.
        stall   = at_end && (ext_wait_s || (slow && (wcnt_q < WS_LIM)));
        advance = at_end && !stall;

        // Phase counter: count up, park on the last phase while stalled.
        ph_d = ph_q;
        if (advance) begin
            ph_d = '0;
        end else if (!at_end) begin
            ph_d = ph_q + 1'b1;
        end

        // Wait counter only lives during a stall and saturates so a long
        // external wait cannot wrap it back under SLOW_WS.
        wcnt_d = '0;
        if (stall) begin
            wcnt_d = (wcnt_q == WCNT_MAX) ? wcnt_q : wcnt_q + 1'b1;
        end

        irq_n_d = advance ? ~|(irq_s & irq_mask) : irq_n;

        // NMI: an edge is always recorded. A pending request is launched only
        // from the high state, so back-to-back requests get a high cycle
        // between pulses. An edge coinciding with the launch stays pending.
        nmi_edge   = nmi_s & ~nmi_prev_q;
        nmi_pend_d = nmi_pend_q | nmi_edge;
        nmi_n_d    = nmi_n;
        if (advance) begin
            if (!nmi_n) begin
                nmi_n_d = 1'b1;
            end else if (nmi_pend_q) begin
                nmi_n_d    = 1'b0;
                nmi_pend_d = nmi_edge;
            end
        end

        rst_cnt_d = rst_cnt_q;
        if (advance && (rst_cnt_q != RST_CNT_MAX)) begin
            rst_cnt_d = rst_cnt_q + 1'b1;
        end
        cpu_reset_n_d = (rst_cnt_d >= RST_LIM);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ph_q        <= '0;
            wcnt_q      <= '0;
            rst_cnt_q   <= '0;
            nmi_prev_q  <= 1'b0;
            nmi_pend_q  <= 1'b0;
            phi0_en     <= 1'b0;
            phi2        <= 1'b0;
            wait_active <= 1'b0;
            irq_n       <= 1'b1;
            nmi_n       <= 1'b1;
            cpu_reset_n <= 1'b0;
        end else begin
            ph_q        <= ph_d;
            wcnt_q      <= wcnt_d;
            rst_cnt_q   <= rst_cnt_d;
            nmi_prev_q  <= nmi_s;
            nmi_pend_q  <= nmi_pend_d;
            phi0_en     <= advance;
            phi2        <= (ph_d >= PH_HALF);
            wait_active <= stall;
            irq_n       <= irq_n_d;
            nmi_n       <= nmi_n_d;
            cpu_reset_n <= cpu_reset_n_d;
        end
    end

endmodule

// File: tb/tb_cpu_cycle_gen.sv
// -----------------------------------------------------------------------------
// tb_cpu_cycle_gen
// Directed table-driven bench for cpu_cycle_gen with DIV=4, SLOW_WS=2,
// RST_CYCLES=8, plus hand-written sequences for waits, IRQ, NMI and reset.
// -----------------------------------------------------------------------------
module tb_cpu_cycle_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] cpu_a;
    logic        ext_wait;
    logic [3:0]  irq_src;
    logic [3:0]  irq_mask;
    logic        nmi_src;
    logic        phi0_en;
    logic        phi2;
    logic        irq_n;
    logic        nmi_n;
    logic        cpu_reset_n;
    logic        wait_active;

    int n_checks = 0;
    int n_fail   = 0;
    int phi0_seen = 0;

    always #5 clk = ~clk;

    cpu_cycle_gen #(
        .DIV        (4),
        .SLOW_BASE  (16'h2000),
        .SLOW_MASK  (16'hE000),
        .SLOW_WS    (2),
        .NUM_IRQ    (4),
        .RST_CYCLES (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cpu_a       (cpu_a),
        .ext_wait    (ext_wait),
        .irq_src     (irq_src),
        .irq_mask    (irq_mask),
        .nmi_src     (nmi_src),
        .phi0_en     (phi0_en),
        .phi2        (phi2),
        .irq_n       (irq_n),
        .nmi_n       (nmi_n),
        .cpu_reset_n (cpu_reset_n),
        .wait_active (wait_active)
    );

    // Output bundle: {phi0_en, phi2, wait_active, irq_n, nmi_n, cpu_reset_n}
    function automatic logic [5:0] outs();
        return {phi0_en, phi2, wait_active, irq_n, nmi_n, cpu_reset_n};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance one clk and sample 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (phi0_en === 1'b1) phi0_seen++;
    endtask

    // Tick until phi0_en is seen; n is the number of ticks taken (bound on timeout).
    task automatic wait_phi0(input int bound, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (phi0_en !== 1'b1 && n < bound);
    endtask

    typedef struct {
        logic [15:0] a;
        logic [5:0]  exp;
    } vec_t;

    vec_t vecs[22];

    initial begin
        int n;
        int low_cnt;
        int trace_pulses;
        int len1, len2, gap, first_low;
        logic [20:0] trace;

        reset    = 1'b1;
        cpu_a    = 16'h0000;
        ext_wait = 1'b0;
        irq_src  = 4'b0000;
        irq_mask = 4'b0000;
        nmi_src  = 1'b0;

        // {phi0_en, phi2, wait_active, irq_n, nmi_n, cpu_reset_n} after each clk
        vecs[0]  = '{16'h0000, 6'b000110};
        vecs[1]  = '{16'h0000, 6'b010110};
        vecs[2]  = '{16'h0000, 6'b010110};
        vecs[3]  = '{16'h0000, 6'b100110};
        vecs[4]  = '{16'h0000, 6'b000110};
        vecs[5]  = '{16'h0000, 6'b010110};
        vecs[6]  = '{16'h0000, 6'b010110};
        vecs[7]  = '{16'h0000, 6'b100110};
        // slow region: two wait states
        vecs[8]  = '{16'h2400, 6'b000110};
        vecs[9]  = '{16'h2400, 6'b010110};
        vecs[10] = '{16'h2400, 6'b010110};
        vecs[11] = '{16'h2400, 6'b011110};
        vecs[12] = '{16'h2400, 6'b011110};
        vecs[13] = '{16'h2400, 6'b100110};
        vecs[14] = '{16'h0000, 6'b000110};
        vecs[15] = '{16'h0000, 6'b010110};
        vecs[16] = '{16'h0000, 6'b010110};
        vecs[17] = '{16'h0000, 6'b100110};
        // slow address away from the last phase is ignored
        vecs[18] = '{16'h2400, 6'b000110};
        vecs[19] = '{16'h2400, 6'b010110};
        vecs[20] = '{16'h2400, 6'b010110};
        vecs[21] = '{16'h0000, 6'b100110};

        tick();
        tick();
        check("reset_state", 32'(outs()), 32'(6'b000110));
        reset = 1'b0;
        phi0_seen = 0;

        for (int i = 0; i < 22; i++) begin
            cpu_a = vecs[i].a;
            tick();
            check($sformatf("vec%0d", i), 32'(outs()), 32'(vecs[i].exp));
        end
        cpu_a = 16'h0000;

        // External wait held 10 clks, released; 2 sync clks plus the last-phase decision.
        ext_wait = 1'b1;
        low_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (phi0_en === 1'b1) low_cnt++;
        end
        check("wait10_no_phi0", 32'(low_cnt), 32'd0);
        check("wait10_active", 32'(wait_active), 32'd1);
        check("wait10_phi2_high", 32'(phi2), 32'd1);
        ext_wait = 1'b0;
        wait_phi0(20, n);
        check("wait10_resume_clks", 32'(n), 32'd3);
        check("wait10_active_clear", 32'(wait_active), 32'd0);

        // External wait held 20 clks: counter saturates instead of wrapping.
        ext_wait = 1'b1;
        low_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (phi0_en === 1'b1) low_cnt++;
        end
        check("wait20_no_phi0", 32'(low_cnt), 32'd0);
        check("wait20_wcnt_sat", 32'(dut.wcnt_q), 32'd15);
        ext_wait = 1'b0;
        wait_phi0(20, n);
        check("wait20_resume_clks", 32'(n), 32'd3);
        check("crn_low_at_7th", 32'(cpu_reset_n), 32'd0);
        check("phi0_count_7", 32'(phi0_seen), 32'd7);

        wait_phi0(20, n);
        check("crn_8th_clks", 32'(n), 32'd4);
        check("crn_high_at_8th", 32'(cpu_reset_n), 32'd1);

        // IRQ masked, then enabled, then source dropped.
        irq_src = 4'b0100;
        wait_phi0(20, n);
        check("irq_masked_a", 32'(irq_n), 32'd1);
        wait_phi0(20, n);
        check("irq_masked_b", 32'(irq_n), 32'd1);
        irq_mask = 4'b0100;
        low_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (irq_n !== 1'b1) low_cnt++;
        end
        check("irq_held_until_phi0", 32'(low_cnt), 32'd0);
        tick();
        check("irq_phi0", 32'(phi0_en), 32'd1);
        check("irq_asserted", 32'(irq_n), 32'd0);
        irq_src = 4'b0000;
        low_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (irq_n !== 1'b0) low_cnt++;
        end
        check("irq_stays_low", 32'(low_cnt), 32'd0);
        tick();
        check("irq_released", 32'(irq_n), 32'd1);
        irq_mask = 4'b0000;

        // NMI: rising edges 3 clks apart -> two pulses with a high cycle between.
        trace = '1;
        for (int k = 1; k <= 20; k++) begin
            if (k == 1) nmi_src = 1'b1;
            if (k == 2) nmi_src = 1'b0;
            if (k == 4) nmi_src = 1'b1;
            if (k == 6) nmi_src = 1'b0;
            tick();
            trace[k] = nmi_n;
        end
        trace_pulses = 0;
        len1 = 0;
        len2 = 0;
        gap = 0;
        first_low = 0;
        for (int k = 1; k <= 20; k++) begin
            if (trace[k] === 1'b0) begin
                if (trace[k-1] === 1'b1) begin
                    trace_pulses++;
                    if (trace_pulses == 1) first_low = k;
                end
                if (trace_pulses == 1) len1++;
                if (trace_pulses == 2) len2++;
            end else if (trace_pulses == 1) begin
                gap++;
            end
        end
        check("nmi_pulses", 32'(trace_pulses), 32'd2);
        check("nmi_first_low", 32'(first_low), 32'd4);
        check("nmi_len1", 32'(len1), 32'd4);
        check("nmi_len2", 32'(len2), 32'd4);
        check("nmi_gap", 32'(gap), 32'd4);

        // Reset asserted mid-stall.
        ext_wait = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check("pre_reset_stall", 32'(wait_active), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_outs", 32'(outs()), 32'(6'b000110));
        ext_wait = 1'b0;
        tick();
        check("reset_no_phi0", 32'(phi0_en), 32'd0);
        reset = 1'b0;
        wait_phi0(20, n);
        check("first_phi0_after_reset", 32'(n), 32'd4);
        check("crn_low_after_reset", 32'(cpu_reset_n), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
